// File: rtl/timer_alarm_if.sv
// Peripheral bus bundle for the timer alarm block: zero-wait-state strobe/ack
// register access with a combinational read path.
interface timer_alarm_if;
  logic [6:0]  addr;
  logic        stb;
  logic        we;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic        ack;

  modport master (output addr, stb, we, dat_w, input dat_r, ack);
  modport slave  (input addr, stb, we, dat_w, output dat_r, ack);
endinterface

// File: rtl/timer_alarm.sv
// Alarm scheduler: NUM_CH seconds/nanoseconds deadlines scanned round-robin
// against the live timer through one shared comparator/adder; level IRQ out.
module timer_alarm #(
  parameter int          NUM_CH     = 4,
  parameter logic [31:0] NS_PER_SEC = 32'd1_000_000_000
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [31:0]   i_sec,
  input  logic [31:0]   i_nsec,
  timer_alarm_if.slave  bus,
  output logic          o_irq
);

  localparam logic [1:0] LAST_CH = 2'(NUM_CH - 1);

  logic [31:0]       cmp_sec_r  [NUM_CH];
  logic [31:0]       cmp_nsec_r [NUM_CH];
  logic [31:0]       period_r   [NUM_CH];
  logic [NUM_CH-1:0] en_r;
  logic [NUM_CH-1:0] periodic_r;
  logic [NUM_CH-1:0] pending_r;
  logic [NUM_CH-1:0] irq_en_r;
  logic [1:0]        ptr_r;
  logic              irq_r;

  logic              wr_s;
  logic              ch_sel_s;
  logic              status_sel_s;
  logic              irq_en_sel_s;
  logic [31:0]       wdat_ns_s;
  logic [31:0]       sel_sec_s;
  logic [31:0]       sel_nsec_s;
  logic [31:0]       sel_period_s;
  logic              due_s;
  logic              reload_s;
  logic [30:0]       sum_s;
  logic              wrap_s;
  logic [31:0]       next_nsec_s;
  logic [NUM_CH-1:0] set_s;
  logic [NUM_CH-1:0] clr_s;
  logic [31:0]       rdata_s;

  function automatic logic [31:0] sat_ns(input logic [31:0] v);
    if (v >= NS_PER_SEC) begin
      return NS_PER_SEC - 32'd1;
    end else begin
      return v;
    end
  endfunction

  // Address decode and write-data conditioning
  always_comb begin
    wr_s         = bus.stb & bus.we;
    ch_sel_s     = ~bus.addr[6] && (bus.addr[1:0] == 2'b00) &&
                   ({1'b0, bus.addr[5:4]} < 3'(NUM_CH));
    status_sel_s = (bus.addr == 7'h40);
    irq_en_sel_s = (bus.addr == 7'h44);
    wdat_ns_s    = sat_ns(bus.dat_w);
  end

  // Shared comparator and reload adder for the channel under the scan pointer
  always_comb begin
    sel_sec_s    = cmp_sec_r[ptr_r];
    sel_nsec_s   = cmp_nsec_r[ptr_r];
    sel_period_s = period_r[ptr_r];
    due_s        = en_r[ptr_r] & ((i_sec > sel_sec_s) |
                   ((i_sec == sel_sec_s) & (i_nsec >= sel_nsec_s)));
    reload_s     = periodic_r[ptr_r] & (sel_period_s != 32'd0);
    // Both operands are below 2^30, so 31 bits hold the sum without overflow
    sum_s        = sel_nsec_s[30:0] + sel_period_s[30:0];
    wrap_s       = (sum_s >= NS_PER_SEC[30:0]);
    next_nsec_s  = wrap_s ? {1'b0, sum_s - NS_PER_SEC[30:0]} : {1'b0, sum_s};
    set_s        = due_s ? (NUM_CH'(1) << ptr_r) : {NUM_CH{1'b0}};
    clr_s        = (wr_s & status_sel_s) ? bus.dat_w[NUM_CH-1:0] : {NUM_CH{1'b0}};
  end

  // Combinational read mux; absent channels and holes read as zero
  always_comb begin
    rdata_s = 32'd0;
    if (ch_sel_s) begin
      case (bus.addr[3:2])
        2'd0:    rdata_s = cmp_sec_r[bus.addr[5:4]];
        2'd1:    rdata_s = cmp_nsec_r[bus.addr[5:4]];
        2'd2:    rdata_s = period_r[bus.addr[5:4]];
        2'd3:    rdata_s = {30'd0, periodic_r[bus.addr[5:4]], en_r[bus.addr[5:4]]};
        default: rdata_s = 32'd0;
      endcase
    end else if (status_sel_s) begin
      rdata_s[NUM_CH-1:0] = pending_r;
    end else if (irq_en_sel_s) begin
      rdata_s[NUM_CH-1:0] = irq_en_r;
    end else begin
      rdata_s = 32'd0;
    end
  end

  assign bus.dat_r = rdata_s;
  assign bus.ack   = bus.stb;
  assign o_irq     = irq_r;

  // Register file, scan pointer, pending and interrupt state
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        cmp_sec_r[c]  <= 32'd0;
        cmp_nsec_r[c] <= 32'd0;
        period_r[c]   <= 32'd0;
      end
      en_r       <= {NUM_CH{1'b0}};
      periodic_r <= {NUM_CH{1'b0}};
      pending_r  <= {NUM_CH{1'b0}};
      irq_en_r   <= {NUM_CH{1'b0}};
      ptr_r      <= 2'd0;
      irq_r      <= 1'b0;
    end else begin
      ptr_r     <= (ptr_r == LAST_CH) ? 2'd0 : ptr_r + 2'd1;
      irq_r     <= |(pending_r & irq_en_r);
      pending_r <= (pending_r & ~clr_s) | set_s;
      if (due_s) begin
        if (reload_s) begin
          cmp_nsec_r[ptr_r] <= next_nsec_s;
          if (wrap_s) begin
            cmp_sec_r[ptr_r] <= sel_sec_s + 32'd1;
          end
        end else begin
          en_r[ptr_r] <= 1'b0;
        end
      end
      // Bus writes come last so they override a same-cycle reload or disarm
      if (wr_s && ch_sel_s) begin
        case (bus.addr[3:2])
          2'd0:    cmp_sec_r[bus.addr[5:4]]  <= bus.dat_w;
          2'd1:    cmp_nsec_r[bus.addr[5:4]] <= wdat_ns_s;
          2'd2:    period_r[bus.addr[5:4]]   <= wdat_ns_s;
          2'd3: begin
            en_r[bus.addr[5:4]]       <= bus.dat_w[0];
            periodic_r[bus.addr[5:4]] <= bus.dat_w[1];
          end
          default: ;
        endcase
      end
      if (wr_s && irq_en_sel_s) begin
        irq_en_r <= bus.dat_w[NUM_CH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_timer_alarm.sv
// Directed self-checking bench for timer_alarm: one task per scenario, expected
// values hand-computed from the register map and scan timing.
module tb_timer_alarm;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] sec;
  logic [31:0] nsec;
  logic        irq;
  int          pass_cnt = 0;
  int          chk_cnt  = 0;
  int          cyc;

  timer_alarm_if bus();

  timer_alarm #(.NUM_CH(4), .NS_PER_SEC(32'd1_000_000_000)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .i_sec (sec),
    .i_nsec(nsec),
    .bus   (bus),
    .o_irq (irq)
  );

  always #5 clk = ~clk;

  // Independent model of the scan pointer: channel (cyc % 4) is evaluated at the next posedge
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, checks %0d/%0d", pass_cnt, chk_cnt);
    $fatal(1, "timeout");
  end

  task automatic wr(input logic [6:0] a, input logic [31:0] d);
    bus.addr = a; bus.we = 1'b1; bus.dat_w = d; bus.stb = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.stb = 1'b0; bus.we = 1'b0;
  endtask

  task automatic rd(input logic [6:0] a, output logic [31:0] d);
    bus.addr = a; bus.we = 1'b0; bus.stb = 1'b1;
    #1;
    d = bus.dat_r;
    bus.stb = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    logic [31:0] d;
    int nz;
    rst = 1'b1;
    cycles(3);
    rst = 1'b0;
    cycles(1);
    nz = 0;
    for (int a = 0; a <= 'h44; a += 4) begin
      rd(7'(a), d);
      if (d != 32'd0) nz++;
    end
    chk_cnt++;
    if (nz !== 0) $display("FAIL reset_regs: nonzero=%0d expected 0", nz);
    else pass_cnt++;
    chk_cnt++;
    if (irq !== 1'b0) $display("FAIL reset_irq: got %b expected 0", irq);
    else pass_cnt++;
    bus.stb = 1'b1; bus.addr = 7'h00; #1;
    chk_cnt++;
    if (bus.ack !== 1'b1) $display("FAIL ack_high: got %b expected 1", bus.ack);
    else pass_cnt++;
    bus.stb = 1'b0; #1;
    chk_cnt++;
    if (bus.ack !== 1'b0) $display("FAIL ack_low: got %b expected 0", bus.ack);
    else pass_cnt++;
    cycles(1);
  endtask

  task automatic test_oneshot;
    logic [31:0] d;
    int k;
    wr(7'h00, 32'd5);
    wr(7'h04, 32'd0);
    wr(7'h44, 32'd1);
    sec = 32'd4; nsec = 32'd999_999_999;
    wr(7'h0C, 32'd1);
    cycles(8);
    rd(7'h40, d);
    chk_cnt++;
    if (d !== 32'd0) $display("FAIL oneshot_early: status=%h expected 0", d);
    else pass_cnt++;
    sec = 32'd5; nsec = 32'd0;
    k = 0; d = 32'd0;
    while (k < 8 && d[0] == 1'b0) begin
      @(negedge clk);
      k++;
      rd(7'h40, d);
    end
    chk_cnt++;
    if (!(d[0] == 1'b1 && k >= 1 && k <= 4))
      $display("FAIL oneshot_latency: cycles=%0d status=%h expected <=4 with bit0", k, d);
    else pass_cnt++;
    chk_cnt++;
    if (irq !== 1'b0) $display("FAIL oneshot_irq_lag: got %b expected 0", irq);
    else pass_cnt++;
    cycles(1);
    chk_cnt++;
    if (irq !== 1'b1) $display("FAIL oneshot_irq: got %b expected 1", irq);
    else pass_cnt++;
    rd(7'h0C, d);
    chk_cnt++;
    if (d !== 32'd0) $display("FAIL oneshot_en_clear: ctrl=%h expected 0", d);
    else pass_cnt++;
    wr(7'h40, 32'd1);
    cycles(1);
    chk_cnt++;
    if (irq !== 1'b0) $display("FAIL oneshot_irq_clear: got %b expected 0", irq);
    else pass_cnt++;
  endtask

  task automatic test_periodic;
    logic [31:0] d;
    wr(7'h44, 32'd0);
    sec = 32'd2; nsec = 32'd0;
    wr(7'h10, 32'd2);
    wr(7'h14, 32'd900_000_000);
    wr(7'h18, 32'd300_000_000);
    wr(7'h1C, 32'd3);
    nsec = 32'd950_000_000;
    cycles(8);
    rd(7'h10, d);
    chk_cnt++;
    if (d !== 32'd3) $display("FAIL periodic_sec: got %0d expected 3", d);
    else pass_cnt++;
    rd(7'h14, d);
    chk_cnt++;
    if (d !== 32'd200_000_000) $display("FAIL periodic_nsec: got %0d expected 200000000", d);
    else pass_cnt++;
    rd(7'h40, d);
    chk_cnt++;
    if (d !== 32'd2) $display("FAIL periodic_pending: status=%h expected 2", d);
    else pass_cnt++;
    rd(7'h1C, d);
    chk_cnt++;
    if (d !== 32'd3) $display("FAIL periodic_ctrl: ctrl=%h expected 3", d);
    else pass_cnt++;
    wr(7'h1C, 32'd0);
    wr(7'h40, 32'd2);
  endtask

  task automatic test_saturate;
    logic [31:0] d;
    wr(7'h38, 32'hFFFF_FFFF);
    rd(7'h38, d);
    chk_cnt++;
    if (d !== 32'd999_999_999) $display("FAIL sat_period: got %0d expected 999999999", d);
    else pass_cnt++;
    wr(7'h34, 32'd1_000_000_000);
    rd(7'h34, d);
    chk_cnt++;
    if (d !== 32'd999_999_999) $display("FAIL sat_cmp_nsec: got %0d expected 999999999", d);
    else pass_cnt++;
    wr(7'h34, 32'd999_999_998);
    rd(7'h34, d);
    chk_cnt++;
    if (d !== 32'd999_999_998) $display("FAIL nosat_cmp_nsec: got %0d expected 999999998", d);
    else pass_cnt++;
    wr(7'h48, 32'hFFFF_FFFF);
    rd(7'h48, d);
    chk_cnt++;
    if (d !== 32'd0) $display("FAIL unmapped: got %h expected 0", d);
    else pass_cnt++;
    wr(7'h30, 32'd1);
    wr(7'h34, 32'd0);
    wr(7'h38, 32'd0);
    wr(7'h3C, 32'd3);
    cycles(8);
    rd(7'h3C, d);
    chk_cnt++;
    if (d !== 32'd2) $display("FAIL period0_ctrl: ctrl=%h expected 2", d);
    else pass_cnt++;
    rd(7'h40, d);
    chk_cnt++;
    if (d !== 32'd8) $display("FAIL period0_pending: status=%h expected 8", d);
    else pass_cnt++;
    rd(7'h30, d);
    chk_cnt++;
    if (d !== 32'd1) $display("FAIL period0_sec: got %0d expected 1", d);
    else pass_cnt++;
    wr(7'h40, 32'd8);
  endtask

  task automatic test_w1c_collision;
    logic [31:0] d;
    wr(7'h44, 32'd4);
    wr(7'h20, 32'd10);
    wr(7'h24, 32'd0);
    wr(7'h2C, 32'd1);
    while (cyc % 4 != 2) @(negedge clk);
    sec = 32'd10; nsec = 32'd0;
    wr(7'h40, 32'd4);
    rd(7'h40, d);
    chk_cnt++;
    if (d !== 32'd4) $display("FAIL w1c_set_wins: status=%h expected 4", d);
    else pass_cnt++;
    chk_cnt++;
    if (irq !== 1'b0) $display("FAIL w1c_irq_lag: got %b expected 0", irq);
    else pass_cnt++;
    cycles(1);
    chk_cnt++;
    if (irq !== 1'b1) $display("FAIL w1c_irq: got %b expected 1", irq);
    else pass_cnt++;
    wr(7'h40, 32'd4);
    rd(7'h40, d);
    chk_cnt++;
    if (d !== 32'd0) $display("FAIL w1c_clear: status=%h expected 0", d);
    else pass_cnt++;
    chk_cnt++;
    if (irq !== 1'b1) $display("FAIL w1c_irq_hold: got %b expected 1", irq);
    else pass_cnt++;
    cycles(1);
    chk_cnt++;
    if (irq !== 1'b0) $display("FAIL w1c_irq_fall: got %b expected 0", irq);
    else pass_cnt++;
  endtask

  task automatic test_all_same;
    logic [31:0] d;
    logic [31:0] exp_tab [4];
    exp_tab[0] = 32'h1; exp_tab[1] = 32'h3; exp_tab[2] = 32'h7; exp_tab[3] = 32'hF;
    wr(7'h44, 32'd0);
    for (int c = 0; c < 4; c++) begin
      wr(7'(c * 16), 32'd20);
      wr(7'(c * 16 + 4), 32'd0);
      wr(7'(c * 16 + 12), 32'd1);
    end
    wr(7'h40, 32'hF);
    while (cyc % 4 != 0) @(negedge clk);
    sec = 32'd20; nsec = 32'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rd(7'h40, d);
      chk_cnt++;
      if (d !== exp_tab[i]) $display("FAIL all_order[%0d]: status=%h expected %h", i, d, exp_tab[i]);
      else pass_cnt++;
    end
    cycles(2);
    chk_cnt++;
    if (irq !== 1'b0) $display("FAIL all_irq_masked: got %b expected 0", irq);
    else pass_cnt++;
  endtask

  task automatic test_catchup_reset;
    logic [31:0] d;
    int nz;
    wr(7'h40, 32'hF);
    wr(7'h44, 32'd1);
    wr(7'h00, 32'd30);
    wr(7'h04, 32'd0);
    wr(7'h08, 32'd100);
    wr(7'h0C, 32'd3);
    while (cyc % 4 != 0) @(negedge clk);
    sec = 32'd30; nsec = 32'd1000;
    for (int v = 0; v < 14; v++) begin
      @(negedge clk);
      rd(7'h40, d);
      chk_cnt++;
      if (d[0] !== (v < 11)) $display("FAIL catchup_visit[%0d]: pending0=%b expected %b", v, d[0], (v < 11));
      else pass_cnt++;
      wr(7'h40, 32'd1);
      repeat (2) @(negedge clk);
    end
    rd(7'h04, d);
    chk_cnt++;
    if (d !== 32'd1100) $display("FAIL catchup_nsec: got %0d expected 1100", d);
    else pass_cnt++;
    rd(7'h00, d);
    chk_cnt++;
    if (d !== 32'd30) $display("FAIL catchup_sec: got %0d expected 30", d);
    else pass_cnt++;
    nsec = 32'd2000;
    cycles(8);
    chk_cnt++;
    if (irq !== 1'b1) $display("FAIL prereset_irq: got %b expected 1", irq);
    else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_cnt++;
    if (irq !== 1'b0) $display("FAIL reset_irq_drop: got %b expected 0", irq);
    else pass_cnt++;
    nz = 0;
    for (int a = 0; a <= 'h44; a += 4) begin
      rd(7'(a), d);
      if (d != 32'd0) nz++;
    end
    chk_cnt++;
    if (nz !== 0) $display("FAIL midreset_regs: nonzero=%0d expected 0", nz);
    else pass_cnt++;
    cycles(8);
    rd(7'h40, d);
    chk_cnt++;
    if (d !== 32'd0 || irq !== 1'b0) $display("FAIL disarmed: status=%h irq=%b expected 0/0", d, irq);
    else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1; sec = 32'd0; nsec = 32'd0;
    bus.addr = 7'h00; bus.stb = 1'b0; bus.we = 1'b0; bus.dat_w = 32'd0;
    @(negedge clk);
    test_reset();
    test_oneshot();
    test_periodic();
    test_saturate();
    test_w1c_collision();
    test_all_same();
    test_catchup_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
